// File: rtl/dict_cam_lru_if.sv
// Request/response bundle for the compression dictionary: write port, forward and reverse lookups.
// master drives requests and writes; slave (the dictionary) returns registered responses.
interface dict_cam_lru_if #(
    parameter int KEY_WIDTH = 3,
    parameter int VAL_WIDTH = 7,
    parameter int CNT_WIDTH = 8
);
    logic                 clear;
    logic                 wr_en;
    logic                 wr_auto;
    logic [KEY_WIDTH-1:0] wr_key;
    logic [VAL_WIDTH-1:0] wr_val;
    logic                 wr_full;
    logic                 key_req;
    logic [KEY_WIDTH-1:0] key_lookup_in;
    logic                 key_rsp;
    logic [VAL_WIDTH-1:0] val_out;
    logic                 val_out_valid;
    logic                 val_req;
    logic [VAL_WIDTH-1:0] val_lookup_in;
    logic                 val_rsp;
    logic                 val_lookup_result;
    logic [KEY_WIDTH-1:0] key_out;
    logic [CNT_WIDTH-1:0] hit_count;

    modport master (
        output clear, wr_en, wr_auto, wr_key, wr_val,
        output key_req, key_lookup_in, val_req, val_lookup_in,
        input  wr_full, key_rsp, val_out, val_out_valid,
        input  val_rsp, val_lookup_result, key_out, hit_count
    );

    modport slave (
        input  clear, wr_en, wr_auto, wr_key, wr_val,
        input  key_req, key_lookup_in, val_req, val_lookup_in,
        output wr_full, key_rsp, val_out, val_out_valid,
        output val_rsp, val_lookup_result, key_out, hit_count
    );
endinterface

// File: rtl/dict_cam_lru.sv
// Code-compression dictionary: forward key->value, reverse CAM value->key with saturating hit counters.
// Both lookups respond one cycle after the request; no backpressure, requests accepted every cycle.
module dict_cam_lru #(
    parameter int KEY_WIDTH = 3,
    parameter int VAL_WIDTH = 7,
    parameter int CNT_WIDTH = 8
) (
    input logic          clk,
    input logic          resetn,
    dict_cam_lru_if.slave bus
);
    localparam int DEPTH = 1 << KEY_WIDTH;

    logic [VAL_WIDTH-1:0] mem_q [DEPTH];
    logic [VAL_WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
    logic [CNT_WIDTH-1:0] cnt_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [KEY_WIDTH-1:0] fill_ptr_q, fill_ptr_d;
    logic                 wr_full_q, wr_full_d;

    logic                 key_rsp_q, key_rsp_d;
    logic [VAL_WIDTH-1:0] val_out_q, val_out_d;
    logic                 val_out_valid_q, val_out_valid_d;
    logic                 val_rsp_q, val_rsp_d;
    logic                 val_lookup_result_q, val_lookup_result_d;
    logic [KEY_WIDTH-1:0] key_out_q, key_out_d;
    logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;

    logic                 hit;
    logic [KEY_WIDTH-1:0] hit_idx;
    logic [KEY_WIDTH-1:0] wr_tgt;

    // Scanning from the top down leaves the lowest matching index as the winner.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (mem_q[i] == bus.val_lookup_in)) begin
                hit     = 1'b1;
                hit_idx = KEY_WIDTH'(i);
            end
        end
    end

    assign wr_tgt = bus.wr_auto ? fill_ptr_q : bus.wr_key;

    always_comb begin
        mem_d               = mem_q;
        cnt_d               = cnt_q;
        valid_d             = valid_q;
        fill_ptr_d          = fill_ptr_q;
        wr_full_d           = wr_full_q;
        key_rsp_d           = bus.key_req;
        val_out_d           = val_out_q;
        val_out_valid_d     = val_out_valid_q;
        val_rsp_d           = bus.val_req;
        val_lookup_result_d = val_lookup_result_q;
        key_out_d           = key_out_q;
        hit_count_d         = hit_count_q;

        // Responses are built from pre-edge state so same-cycle writes/clears are not visible.
        if (bus.key_req) begin
            val_out_d       = mem_q[bus.key_lookup_in];
            val_out_valid_d = valid_q[bus.key_lookup_in];
        end

        if (bus.val_req) begin
            val_lookup_result_d = hit;
            key_out_d           = hit ? hit_idx : '0;
            hit_count_d         = hit ? cnt_q[hit_idx] : '0;
            if (hit && (cnt_q[hit_idx] != {CNT_WIDTH{1'b1}})) begin
                cnt_d[hit_idx] = cnt_q[hit_idx] + 1'b1;
            end
        end

        // Applied after the hit increment so a write or clear zeroes the counter last.
        if (bus.clear) begin
            valid_d    = '0;
            fill_ptr_d = '0;
            wr_full_d  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (bus.wr_en) begin
            mem_d[wr_tgt]   = bus.wr_val;
            valid_d[wr_tgt] = 1'b1;
            cnt_d[wr_tgt]   = '0;
            if (bus.wr_auto) begin
                fill_ptr_d = fill_ptr_q + 1'b1;
                if (fill_ptr_q == {KEY_WIDTH{1'b1}}) begin
                    wr_full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q               <= '{default: '0};
            cnt_q               <= '{default: '0};
            valid_q             <= '0;
            fill_ptr_q          <= '0;
            wr_full_q           <= 1'b0;
            key_rsp_q           <= 1'b0;
            val_out_q           <= '0;
            val_out_valid_q     <= 1'b0;
            val_rsp_q           <= 1'b0;
            val_lookup_result_q <= 1'b0;
            key_out_q           <= '0;
            hit_count_q         <= '0;
        end else begin
            mem_q               <= mem_d;
            cnt_q               <= cnt_d;
            valid_q             <= valid_d;
            fill_ptr_q          <= fill_ptr_d;
            wr_full_q           <= wr_full_d;
            key_rsp_q           <= key_rsp_d;
            val_out_q           <= val_out_d;
            val_out_valid_q     <= val_out_valid_d;
            val_rsp_q           <= val_rsp_d;
            val_lookup_result_q <= val_lookup_result_d;
            key_out_q           <= key_out_d;
            hit_count_q         <= hit_count_d;
        end
    end

    assign bus.wr_full           = wr_full_q;
    assign bus.key_rsp           = key_rsp_q;
    assign bus.val_out           = val_out_q;
    assign bus.val_out_valid     = val_out_valid_q;
    assign bus.val_rsp           = val_rsp_q;
    assign bus.val_lookup_result = val_lookup_result_q;
    assign bus.key_out           = key_out_q;
    assign bus.hit_count         = hit_count_q;
endmodule

// File: tb/tb_dict_cam_lru.sv
// Directed bench for dict_cam_lru: expected responses are queued at issue time and
// popped by an independent monitor whenever a response pulse is seen.
module tb_dict_cam_lru;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [6:0] val;
        logic       vld;
        logic       chk_val;
    } fexp_t;

    typedef struct {
        logic       hit;
        logic [2:0] key;
        logic [7:0] cnt;
    } rexp_t;

    fexp_t fq[$];
    rexp_t rq[$];

    dict_cam_lru_if #(.KEY_WIDTH(3), .VAL_WIDTH(7), .CNT_WIDTH(8)) bus ();

    dict_cam_lru #(.KEY_WIDTH(3), .VAL_WIDTH(7), .CNT_WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outs(input string name);
        check(name, {13'd0, bus.key_rsp, bus.val_out, bus.val_out_valid, bus.val_rsp,
                     bus.val_lookup_result, bus.key_out, bus.hit_count, bus.wr_full}, 32'd0);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.key_rsp) begin
                if (fq.size() == 0) begin
                    check("unexpected_key_rsp", 32'd1, 32'd0);
                end else begin
                    automatic fexp_t e = fq.pop_front();
                    if (e.chk_val) check("fwd_val_out", 32'(bus.val_out), 32'(e.val));
                    check("fwd_val_out_valid", 32'(bus.val_out_valid), 32'(e.vld));
                end
            end
            if (bus.val_rsp) begin
                if (rq.size() == 0) begin
                    check("unexpected_val_rsp", 32'd1, 32'd0);
                end else begin
                    automatic rexp_t r = rq.pop_front();
                    check("rev_result", 32'(bus.val_lookup_result), 32'(r.hit));
                    check("rev_key_out", 32'(bus.key_out), 32'(r.key));
                    check("rev_hit_count", 32'(bus.hit_count), 32'(r.cnt));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear = 0; bus.wr_en = 0; bus.wr_auto = 0; bus.wr_key = '0; bus.wr_val = '0;
        bus.key_req = 0; bus.key_lookup_in = '0; bus.val_req = 0; bus.val_lookup_in = '0;
    endtask

    task automatic fwd(input logic [2:0] k, input logic [6:0] v, input logic vld, input logic chk_val);
        bus.key_req = 1; bus.key_lookup_in = k;
        fq.push_back('{val: v, vld: vld, chk_val: chk_val});
        tick();
        bus.key_req = 0;
    endtask

    task automatic rev(input logic [6:0] v, input logic h, input logic [2:0] k, input logic [7:0] c);
        bus.val_req = 1; bus.val_lookup_in = v;
        rq.push_back('{hit: h, key: k, cnt: c});
        tick();
        bus.val_req = 0;
    endtask

    task automatic wr(input logic auto_m, input logic [2:0] k, input logic [6:0] v);
        bus.wr_en = 1; bus.wr_auto = auto_m; bus.wr_key = k; bus.wr_val = v;
        tick();
        bus.wr_en = 0; bus.wr_auto = 0;
    endtask

    initial begin
        idle();
        #12;
        check_zero_outs("reset_outputs");
        @(negedge clk);
        resetn = 1;
        tick();

        // Fill all 8 entries round-robin; wr_full rises only on the wrap.
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, 3'd0, 7'(i + 1));
            check("wr_full_fill", 32'(bus.wr_full), (i == 7) ? 32'd1 : 32'd0);
        end
        fwd(3'd7, 7'b0001000, 1'b1, 1'b1);
        tick();

        // Repeated reverse hits report the pre-hit counter value.
        rev(7'b0000100, 1'b1, 3'd3, 8'd0);
        rev(7'b0000100, 1'b1, 3'd3, 8'd1);
        rev(7'b0000100, 1'b1, 3'd3, 8'd2);
        rev(7'b1111111, 1'b0, 3'd0, 8'd0);

        // Duplicate value: lowest index wins; write on the hit entry zeroes its counter.
        wr(1'b0, 3'd5, 7'b0010111);
        wr(1'b0, 3'd2, 7'b0010111);
        rev(7'b0010111, 1'b1, 3'd2, 8'd0);
        bus.wr_en = 1; bus.wr_auto = 0; bus.wr_key = 3'd2; bus.wr_val = 7'b0010111;
        rev(7'b0010111, 1'b1, 3'd2, 8'd1);
        bus.wr_en = 0;
        rev(7'b0010111, 1'b1, 3'd2, 8'd0);

        // Entry 3 already has 3 hits; the counter must stop at 255.
        for (int i = 0; i < 300; i++) begin
            rev(7'b0000100, 1'b1, 3'd3, (i + 3 > 255) ? 8'd255 : 8'(i + 3));
        end
        tick();

        // Clear drops the same-cycle write and resets the fill pointer.
        bus.clear = 1; bus.wr_en = 1; bus.wr_auto = 0; bus.wr_key = 3'd1; bus.wr_val = 7'd99;
        tick();
        bus.clear = 0; bus.wr_en = 0;
        check("wr_full_after_clear", 32'(bus.wr_full), 32'd0);
        fwd(3'd1, 7'd0, 1'b0, 1'b0);
        fwd(3'd3, 7'd0, 1'b0, 1'b0);
        rev(7'd99, 1'b0, 3'd0, 8'd0);
        rev(7'b0000100, 1'b0, 3'd0, 8'd0);
        rev(7'b0000010, 1'b0, 3'd0, 8'd0);
        wr(1'b1, 3'd6, 7'd55);
        fwd(3'd0, 7'd55, 1'b1, 1'b1);
        rev(7'd55, 1'b1, 3'd0, 8'd0);
        tick();

        // Async reset lands mid-cycle while a forward response is in flight.
        bus.key_req = 1; bus.key_lookup_in = 3'd0;
        @(posedge clk);
        #2;
        resetn = 0;
        #1;
        check_zero_outs("async_reset_outputs");
        bus.key_req = 0;
        @(negedge clk);
        resetn = 1;
        repeat (4) tick();
        check_zero_outs("post_reset_quiet");
        fwd(3'd0, 7'd0, 1'b0, 1'b1);
        repeat (3) tick();

        check("fwd_queue_drained", 32'(fq.size()), 32'd0);
        check("rev_queue_drained", 32'(rq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
